// File: rtl/click_encoder.sv
// Click-protocol transmitter: emits N fixed-width pulses, a quiet gap,
// then a one-cycle done strobe.
module click_encoder #(
  parameter int unsigned HIGH_CYCLES = 3,
  parameter int unsigned LOW_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES  = 5,
  parameter int unsigned TIMER_WIDTH = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] count,
  output logic       pulse_out,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [TIMER_WIDTH-1:0] T_HIGH =
    TIMER_WIDTH'(HIGH_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T_LOW =
    TIMER_WIDTH'(LOW_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T_GAP =
    TIMER_WIDTH'(GAP_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T_ONE =
    TIMER_WIDTH'(1);

  logic [1:0]             state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [2:0]             rem_q, rem_d;
  logic                   done_d;
  logic                   tmr_zero;

  assign tmr_zero = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && count != 3'd0) begin
          rem_d   = count;
          timer_d = T_HIGH;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (!tmr_zero) begin
          timer_d = timer_q - T_ONE;
        end else if (rem_q > 3'd1) begin
          rem_d   = rem_q - 3'd1;
          timer_d = T_LOW;
          state_d = S_LOW;
        end else begin
          timer_d = T_GAP;
          state_d = S_GAP;
        end
      end
      S_LOW: begin
        if (!tmr_zero) begin
          timer_d = timer_q - T_ONE;
        end else begin
          timer_d = T_HIGH;
          state_d = S_HIGH;
        end
      end
      S_GAP: begin
        if (!tmr_zero) begin
          timer_d = timer_q - T_ONE;
        end else begin
          rem_d   = 3'd0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // Outputs are registered alongside the state they decode from.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      rem_q     <= 3'd0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rem_q     <= rem_d;
      pulse_out <= (state_d == S_HIGH);
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_click_encoder.sv
// Directed bench for click_encoder: captures per-cycle output traces
// and compares them against hand-computed bit patterns.
module tb_click_encoder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] count;
  logic       pulse_out;
  logic       busy;
  logic       done;

  int n_tests;
  int n_fail;

  click_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit i-1 of each trace holds cycle i after the start edge.
  task automatic run(
    input  logic [2:0]  c0,
    input  int          n,
    input  int          s_from,
    input  int          s_to,
    input  logic [2:0]  c1,
    output logic [63:0] p,
    output logic [63:0] b,
    output logic [63:0] d
  );
    p = '0;
    b = '0;
    d = '0;
    start = 1'b1;
    count = c0;
    @(negedge clk);
    for (int i = 1; i <= n; i++) begin
      p[i-1] = pulse_out;
      b[i-1] = busy;
      d[i-1] = done;
      start = (i >= s_from) && (i <= s_to);
      count = (i >= s_from) ? c1 : c0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || done) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [63:0] rises(input logic [63:0] v);
    return v & ~(v << 1);
  endfunction

  logic [63:0] p, b, d;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    count   = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_pulse", {63'd0, pulse_out}, 64'd0);
    check("rst_busy",  {63'd0, busy},      64'd0);
    check("rst_done",  {63'd0, done},      64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // count=1: high 1-3, busy 1-8, done 9
    run(3'd1, 10, 99, 0, 3'd1, p, b, d);
    check("c1_pulse", p, 64'h007);
    check("c1_busy",  b, 64'h0FF);
    check("c1_done",  d, 64'h100);

    // count=2: high 1-3 and 6-8, busy 13 cycles, done 14
    run(3'd2, 15, 99, 0, 3'd2, p, b, d);
    check("c2_pulse", p, 64'h00E7);
    check("c2_busy",  b, 64'h1FFF);
    check("c2_done",  d, 64'h2000);

    // count=7: 38 busy cycles, done on cycle 39
    run(3'd7, 45, 99, 0, 3'd7, p, b, d);
    check("c7_high",  64'($countones(p)), 64'd21);
    check("c7_npulse", 64'($countones(rises(p))), 64'd7);
    check("c7_busy",  b, (64'd1 << 38) - 64'd1);
    check("c7_done",  d, 64'd1 << 38);
    check("c7_ovl",   b & d, 64'd0);

    // count=0 is ignored
    run(3'd0, 50, 99, 0, 3'd0, p, b, d);
    check("c0_pulse", p, 64'd0);
    check("c0_busy",  b, 64'd0);
    check("c0_done",  d, 64'd0);

    // start re-asserted with count=5 mid-burst has no effect
    run(3'd2, 15, 2, 10, 3'd5, p, b, d);
    check("mid_pulse", p, 64'h00E7);
    check("mid_busy",  b, 64'h1FFF);
    check("mid_done",  d, 64'h2000);

    // start held: back-to-back bursts with a 9-cycle period
    run(3'd1, 27, 1, 26, 3'd1, p, b, d);
    check("b2b_pulse", p,
          (64'h7 << 0) | (64'h7 << 9) | (64'h7 << 18));
    check("b2b_busy", b,
          (64'hFF << 0) | (64'hFF << 9) | (64'hFF << 18));
    check("b2b_done", d,
          (64'd1 << 8) | (64'd1 << 17) | (64'd1 << 26));
    wait_idle();

    // reset during second HIGH of a count=3 burst
    run(3'd3, 6, 99, 0, 3'd3, p, b, d);
    check("ab_pre", {63'd0, pulse_out}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("ab_pulse", {63'd0, pulse_out}, 64'd0);
    check("ab_busy",  {63'd0, busy},      64'd0);
    check("ab_done",  {63'd0, done},      64'd0);
    rst_n = 1'b1;
    run(3'd0, 12, 99, 0, 3'd0, p, b, d);
    check("ab_quiet", p | b | d, 64'd0);

    // fresh burst after reset behaves normally
    run(3'd1, 10, 99, 0, 3'd1, p, b, d);
    check("ar_pulse", p, 64'h007);
    check("ar_busy",  b, 64'h0FF);
    check("ar_done",  d, 64'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
